seq_divider_6by3: RTL and testbench
===================================

Name: seq_divider_6by3

Overview:
- Sequential restoring divider; the inverse of the team's 3-bit array multiplier.
- Divides an N_W-bit unsigned dividend by a D_W-bit unsigned divisor and produces the quotient and remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath. Uses a start/busy/done handshake toward the controlling FSM.

Parameters:
- N_W, 6, dividend and quotient width.
- D_W, 3, divisor and remainder width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  N_W  unsigned dividend; captured on accepted start.
- divisor  input  D_W  unsigned divisor; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  N_W  result quotient; held until the next completion.
- remainder  output  D_W  result remainder; held until the next completion.
- div_by_zero  output  1  set with done when the captured divisor was 0; held with the results.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers 0.
- FSM states: IDLE, RUN.
- IDLE, start=1, divisor!=0 (edge E0):
  - Capture operands; rem_acc(D_W+1 bits)=0; bit index=N_W-1.
  - Go to RUN; busy=1.
- IDLE, start=1, divisor==0 (edge E0):
  - No iteration. At E0: quotient=all ones (6'h3F), remainder=dividend[D_W-1:0], div_by_zero=1, done=1.
  - Stay in IDLE; busy stays 0.
- RUN, one iteration per edge E1..E_N_W:
  - rem_acc = {rem_acc[D_W-1:0], dividend_q[idx]}.
  - If rem_acc >= divisor_q: rem_acc -= divisor_q and q[idx]=1; else q[idx]=0.
  - Decrement idx.
- Last iteration (edge E_N_W, E6 by default):
  - Write quotient and remainder (rem_acc[D_W-1:0]); div_by_zero=0; done=1; busy=0; return to IDLE.
- Latency: done high in the cycle after E6, i.e. 6 cycles after start acceptance for non-zero divisors. Divide-by-zero latency is 1.
- done is high for exactly one cycle. It is cleared on the next edge unless a new divide-by-zero completes on that edge.
- start while busy=1 is ignored and not queued. Operand changes during RUN have no effect.
- start in the cycle done=1 (state IDLE) is accepted normally. Back-to-back throughput is one operation per N_W+1 cycles.
- Outputs change only at completion, never mid-operation.
- rst_n low at any time, including mid-RUN: immediately return to reset values. No done is produced for the aborted operation.
- Arithmetic: unsigned only. rem_acc needs D_W+1 bits because the shifted value is < 2*divisor.
- Invariant for divisor!=0: quotient*divisor + remainder == dividend, and remainder < divisor.

Optional Feature:
- Macro: DIV_RESULT_CHECK_EN.
- Defined:
  - Adds output check_err (1 bit, reset 0).
  - On each non-zero-divisor completion, registered together with done: check_err = (quotient*divisor_q + remainder != dividend_q) || (remainder >= divisor_q).
  - check_err is held until the next completion. It is cleared on divide-by-zero completions.
- Undefined: no check_err port or logic. All other behaviour identical.

Test Plan:
- Reset, then start with dividend=45, divisor=6 -> after 6 cycles done=1 for one cycle, quotient=7, remainder=3, div_by_zero=0; busy high for exactly 6 cycles.
- dividend=63, divisor=7 -> quotient=9, remainder=0. Then dividend=5, divisor=7 -> quotient=0, remainder=5.
- dividend=42, divisor=0 -> next cycle done=1, quotient=63, remainder=2, div_by_zero=1, busy never asserted.
- Start 45/6, then pulse start with 63/7 at cycle 3 -> ignored; result is 7 r3. start asserted during the done cycle -> accepted, second result 9 r0 seven cycles later.
- Start 45/6, drop rst_n at cycle 3 -> all outputs 0 immediately, no done pulse. After release, 20/3 -> quotient=6, remainder=2.
- Exhaustive sweep of all 64x7 non-zero-divisor operand pairs checked against a reference model. With DIV_RESULT_CHECK_EN, check_err stays 0 throughout.

Source files
------------

// File: rtl/seq_divider_6by3.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Ports: clk, rst_n, start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero
//        (+ check_err when DIV_RESULT_CHECK_EN is defined).
module seq_divider_6by3 #(
  parameter int N_W = 6,
  parameter int D_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
`ifdef DIV_RESULT_CHECK_EN
  output logic           check_err,
`endif
  output logic           div_by_zero
);

  localparam int IW = (N_W > 1) ? $clog2(N_W) : 1;
  localparam int PW = N_W + D_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [N_W-1:0] dvd_q, dvd_d;
  logic [D_W-1:0] dvs_q, dvs_d;
  // Partial remainder after subtraction is always < divisor, so D_W bits
  // suffice in storage; the D_W+1-bit width lives in the shifted value.
  logic [D_W-1:0] acc_q, acc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N_W-1:0] qacc_q, qacc_d;
  logic [N_W-1:0] quo_q, quo_d;
  logic [D_W-1:0] rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           done_q, done_d;
`ifdef DIV_RESULT_CHECK_EN
  logic           chk_q, chk_d;
  logic [PW-1:0]  recon;
`endif

  logic [D_W:0]   shifted;
  logic [D_W:0]   acc_nxt;
  logic           ge;
  logic [N_W-1:0] q_nxt;
  logic           last;
  logic           accept;
  logic           zero;

  // Iteration datapath
  always_comb begin
    shifted = {acc_q, dvd_q[idx_q]};
    ge      = shifted >= {1'b0, dvs_q};
    acc_nxt = ge ? (shifted - {1'b0, dvs_q}) : shifted;
    q_nxt        = qacc_q;
    q_nxt[idx_q] = ge;
    last   = (idx_q == '0);
    accept = (state_q == IDLE) && start;
    zero   = (divisor == '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && !zero) state_d = RUN;
      RUN:  if (last)            state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == RUN);
  end

`ifdef DIV_RESULT_CHECK_EN
  always_comb begin
    recon = PW'(q_nxt) * PW'(dvs_q) + PW'(acc_nxt[D_W-1:0]);
  end
`endif

  // Datapath next values
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    qacc_d = qacc_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
`ifdef DIV_RESULT_CHECK_EN
    chk_d  = chk_q;
`endif
    unique case (1'b1)
      accept && zero: begin
        quo_d  = '1;
        rem_d  = dividend[D_W-1:0];
        dbz_d  = 1'b1;
        done_d = 1'b1;
`ifdef DIV_RESULT_CHECK_EN
        chk_d  = 1'b0;
`endif
      end
      accept && !zero: begin
        dvd_d  = dividend;
        dvs_d  = divisor;
        acc_d  = '0;
        qacc_d = '0;
        idx_d  = IW'(N_W - 1);
      end
      state_q == RUN: begin
        acc_d  = acc_nxt[D_W-1:0];
        qacc_d = q_nxt;
        idx_d  = idx_q - IW'(1);
        if (last) begin
          quo_d  = q_nxt;
          rem_d  = acc_nxt[D_W-1:0];
          dbz_d  = 1'b0;
          done_d = 1'b1;
`ifdef DIV_RESULT_CHECK_EN
          chk_d  = (recon != PW'(dvd_q)) ||
                   (acc_nxt[D_W-1:0] >= dvs_q);
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      qacc_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef DIV_RESULT_CHECK_EN
      chk_q  <= 1'b0;
`endif
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      qacc_q <= qacc_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
      done_q <= done_d;
`ifdef DIV_RESULT_CHECK_EN
      chk_q  <= chk_d;
`endif
    end
  end

  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
`ifdef DIV_RESULT_CHECK_EN
  assign check_err   = chk_q;
`endif

endmodule

// File: tb/tb_seq_divider_6by3.sv
// Testbench for seq_divider_6by3: vector table, handshake corner cases,
// and a sweep of all non-zero-divisor operand pairs.
module tb_seq_divider_6by3;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       div_by_zero;
`ifdef DIV_RESULT_CHECK_EN
  logic       check_err;
`endif

  int checks;
  int failures;

  seq_divider_6by3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
`ifdef DIV_RESULT_CHECK_EN
    .check_err  (check_err),
`endif
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] dv;
    logic [2:0] ds;
    logic [5:0] q;
    logic [2:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at a negedge; drives start for one cycle and waits (bounded)
  // for done. lat counts negedges from start assertion to done visible.
  task automatic run_op(input logic [5:0] dv, input logic [2:0] ds,
                        output int lat, output int bc, output bit ok);
    start    = 1'b1;
    dividend = dv;
    divisor  = ds;
    bc  = 0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    ok = done;
  endtask

  int  lat, bc, nd;
  bit  ok;
  int  eq, er;
  bit  sweep_bad;

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;

    vecs[0] = '{6'd45, 3'd6, 6'd7,  3'd3, 1'b0, 7};
    vecs[1] = '{6'd63, 3'd7, 6'd9,  3'd0, 1'b0, 7};
    vecs[2] = '{6'd5,  3'd7, 6'd0,  3'd5, 1'b0, 7};
    vecs[3] = '{6'd42, 3'd0, 6'd63, 3'd2, 1'b1, 1};
    vecs[4] = '{6'd0,  3'd1, 6'd0,  3'd0, 1'b0, 7};
    vecs[5] = '{6'd63, 3'd1, 6'd63, 3'd0, 1'b0, 7};
    vecs[6] = '{6'd7,  3'd0, 6'd63, 3'd7, 1'b1, 1};
    vecs[7] = '{6'd1,  3'd7, 6'd0,  3'd1, 1'b0, 7};
    vecs[8] = '{6'd20, 3'd3, 6'd6,  3'd2, 1'b0, 7};
    vecs[9] = '{6'd62, 3'd5, 6'd12, 3'd2, 1'b0, 7};

    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_q", int'(quotient), 0);
    chk("reset_r", int'(remainder), 0);
    chk("reset_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].dv, vecs[i].ds, lat, bc, ok);
      chk($sformatf("v%0d_done", i), int'(ok), 1);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy", i), bc, vecs[i].dbz ? 0 : 6);
      chk($sformatf("v%0d_q", i), int'(quotient), int'(vecs[i].q));
      chk($sformatf("v%0d_r", i), int'(remainder), int'(vecs[i].r));
      chk($sformatf("v%0d_dbz", i), int'(div_by_zero), int'(vecs[i].dbz));
`ifdef DIV_RESULT_CHECK_EN
      chk($sformatf("v%0d_cerr", i), int'(check_err), 0);
`endif
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), int'(done), 0);
    end

    // Start during busy is ignored; results held mid-run
    start = 1'b1; dividend = 6'd45; divisor = 3'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 6'd63; divisor = 3'd7;
    @(negedge clk);
    start = 1'b0; dividend = 6'd0; divisor = 3'd1;
    chk("hold_q_midrun", int'(quotient), 12);
    chk("hold_r_midrun", int'(remainder), 2);
    nd = 3;
    while (!done && nd < 20) begin
      @(negedge clk);
      nd++;
    end
    chk("ign_lat", nd, 7);
    chk("ign_q", int'(quotient), 7);
    chk("ign_r", int'(remainder), 3);

    // Start in the done cycle is accepted (back-to-back)
    run_op(6'd63, 3'd7, lat, bc, ok);
    chk("b2b_done", int'(ok), 1);
    chk("b2b_lat", lat, 7);
    chk("b2b_q", int'(quotient), 9);
    chk("b2b_r", int'(remainder), 0);

    // Divide-by-zero right after: done must re-pulse, busy stays low
    run_op(6'd42, 3'd0, lat, bc, ok);
    chk("dz_lat", lat, 1);
    chk("dz_busy", bc + int'(busy), 0);
    chk("dz_q", int'(quotient), 63);
    chk("dz_dbz", int'(div_by_zero), 1);
    @(negedge clk);

    // Reset mid-run aborts with no done
    start = 1'b1; dividend = 6'd45; divisor = 3'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_op(6'd20, 3'd3, lat, bc, ok);
    chk("post_lat", lat, 7);
    chk("post_q", int'(quotient), 6);
    chk("post_r", int'(remainder), 2);

    // Sweep against a reference model
    for (int a = 0; a < 64; a++) begin
      for (int b = 1; b < 8; b++) begin
        run_op(6'(a), 3'(b), lat, bc, ok);
        eq = a / b;
        er = a % b;
        sweep_bad = !ok || lat != 7 || int'(quotient) != eq ||
                    int'(remainder) != er || div_by_zero;
`ifdef DIV_RESULT_CHECK_EN
        sweep_bad = sweep_bad || check_err;
`endif
        checks++;
        if (sweep_bad) begin
          failures++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=7",
                   a, b, quotient, remainder, lat, eq, er);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
